// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, combinational imem read, next-PC selection, run/step/halt FSM.
// Define FETCH_DELAY_SLOT_EN to make taken branches/jumps take effect after one delay slot.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 64,
    parameter int unsigned ADDR_W     = 6,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              run,
    input  logic              step,
    input  logic              branch,
    input  logic              jump,
    input  logic              zero,
    input  logic [15:0]       imm16,
    input  logic [25:0]       instr_index,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic [31:0]       pc,
    output logic [31:0]       instr,
    output logic [1:0]        state,
    output logic              fault,
    output logic [31:0]       retired
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_retired;
    logic        r_fault;
    logic        r_step_q;
`ifdef FETCH_DELAY_SLOT_EN
    logic        r_pending;
    logic [31:0] r_target;
`endif

    logic        w_active;
    logic        w_in_range;
    logic        w_is_halt;
    logic        w_exec;
    logic        w_step_rise;
    logic        w_taken;
    logic [31:0] w_pc4;
    logic [31:0] w_jump_tgt;
    logic [31:0] w_br_tgt;
    logic [31:0] w_target;

    assign w_active    = (r_state == S_RUN) || (r_state == S_STEP);
    assign w_in_range  = ({2'b00, r_pc[31:2]} < IMEM_DEPTH);
    assign w_is_halt   = (imem_data == HALT_WORD);
    assign w_exec      = w_active && w_in_range && !w_is_halt;
    assign w_step_rise = step && !r_step_q;

    assign w_pc4      = r_pc + 32'd4;
    assign w_jump_tgt = {w_pc4[31:28], instr_index, 2'b00};
    assign w_br_tgt   = w_pc4 + {{14{imm16[15]}}, imm16, 2'b00};
    // Jump takes priority over a simultaneously asserted taken branch.
    assign w_taken    = jump || (branch && zero);
    assign w_target   = jump ? w_jump_tgt : w_br_tgt;

    assign imem_addr = r_pc[ADDR_W+1:2];
    assign instr     = w_exec ? imem_data : 32'h0000_0000;
    assign pc        = r_pc;
    assign state     = r_state;
    assign fault     = r_fault;
    assign retired   = r_retired;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_pc      <= RESET_PC;
            r_state   <= S_IDLE;
            r_fault   <= 1'b0;
            r_retired <= '0;
            r_step_q  <= 1'b0;
`ifdef FETCH_DELAY_SLOT_EN
            r_pending <= 1'b0;
            r_target  <= RESET_PC;
`endif
        end else begin
            r_step_q <= step;

            if (w_exec) begin
                r_retired <= r_retired + 32'd1;
`ifdef FETCH_DELAY_SLOT_EN
                // The delay-slot instruction itself never redirects.
                if (r_pending) begin
                    r_pc      <= r_target;
                    r_pending <= 1'b0;
                end else if (w_taken) begin
                    r_pc      <= w_pc4;
                    r_target  <= w_target;
                    r_pending <= 1'b1;
                end else begin
                    r_pc <= w_pc4;
                end
`else
                r_pc <= w_taken ? w_target : w_pc4;
`endif
            end

            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state <= S_RUN;
                    end else if (w_step_rise) begin
                        r_state <= S_STEP;
                    end
                end
                S_RUN, S_STEP: begin
                    if (!w_in_range) begin
                        r_state <= S_HALT;
                        r_fault <= 1'b1;
`ifdef FETCH_DELAY_SLOT_EN
                        r_pending <= 1'b0;
`endif
                    end else if (w_is_halt) begin
                        r_state <= S_HALT;
`ifdef FETCH_DELAY_SLOT_EN
                        r_pending <= 1'b0;
`endif
                    end else if ((r_state == S_STEP) || !run) begin
                        r_state <= S_IDLE;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the execute stage. Holds the program counter and reads the instruction memory at that PC.
- Presents pc/instr to the execute stage. Computes the next PC from the branch/jump/zero/imm16/instr_index fed back by the execute stage.
- Adds run/single-step/halt control so the core can be stepped from board switches.

Parameters:
- RESET_PC, 32'h00000000, PC loaded on reset; word-aligned.
- IMEM_DEPTH, 64, instruction memory depth in 32-bit words.
- ADDR_W, 6, imem word-address width; clog2(IMEM_DEPTH).
- HALT_WORD, 32'hFFFFFFFF, instruction encoding that stops fetch.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST_N  in  1  synchronous active-low reset.
- run  in  1  level; 1 = free-run.
- step  in  1  rising edge = execute exactly one instruction.
- branch  in  1  from execute stage; current instr is a conditional branch.
- jump  in  1  from execute stage; current instr is a jump.
- zero  in  1  from execute stage; ALU zero flag.
- imm16  in  16  from execute stage; branch offset in words.
- instr_index  in  26  from execute stage; jump target index.
- imem_addr  out  ADDR_W  word address = pc[ADDR_W+1:2].
- imem_data  in  32  combinational read data for imem_addr.
- pc  out  32  current PC to execute stage.
- instr  out  32  instruction to execute stage; 32'h0 (NOP) when not executing.
- state  out  2  IDLE=0, RUN=1, STEP=2, HALT=3.
- fault  out  1  sticky; PC left instruction memory.
- retired  out  32  count of executed instructions.

Behaviour:
- Reset (RST_N=0 at posedge): pc=RESET_PC, state=IDLE, fault=0, retired=0, step_q=0, delay-slot pending cleared. Reset mid-RUN or mid-STEP abandons the current instruction and performs no PC update.
- step_q registers step every cycle. step_rise = step & ~step_q.
- exec = (state==RUN or STEP) & in_range & (imem_data != HALT_WORD), where in_range = pc[31:2] < IMEM_DEPTH.
- instr = exec ? imem_data : 32'h0. The NOP keeps register-file and data-memory writes benign, and the execute stage returns branch=jump=0 for it.
- Next PC:
  - pc4 = pc+4.
  - jump: {pc4[31:28], instr_index, 2'b00}.
  - else branch&zero: pc4 + {{14{imm16[15]}}, imm16, 2'b00}, 32-bit wraparound.
  - else pc4.
  - jump has priority over branch.
- On posedge with exec=1: pc<=next PC; retired<=retired+1, wrapping 32'hFFFFFFFF->0. With exec=0, pc and retired hold.
- FSM transitions:
  - IDLE: run=1 -> RUN. Else step_rise -> STEP. If both, run wins.
  - RUN: run=0 -> IDLE. The instruction presented in that cycle still executes.
  - STEP: always -> IDLE after its one cycle. Step edges during STEP are ignored.
  - RUN/STEP with imem_data==HALT_WORD and in_range -> HALT. PC holds at the halt word's address.
  - RUN/STEP with !in_range -> HALT, fault<=1.
  - HALT: stays until reset. run and step are ignored.
- One instruction per cycle in RUN; zero-cycle fetch latency (combinational imem).

Optional Feature:
- Macro: FETCH_DELAY_SLOT_EN.
- Defined (MIPS delay slot):
  - A taken jump or branch does not redirect immediately. pc<=pc4 and the target is latched with pending=1.
  - The next executed instruction (delay slot) runs; then pc<=latched target and pending clears.
  - A branch or jump inside a delay slot is ignored for redirection.
  - A halt word or fault in the delay slot enters HALT and clears pending.
  - Leaving RUN to IDLE keeps pending, so stepping through a delay slot behaves identically.
- Undefined: redirect takes effect on the posedge following the branch/jump, with no pending register.

Test Plan:
- Reset, run=1, imem words 0..3 = ADD-type words, word 4 = 32'hFFFFFFFF -> pc 0,4,8,12,16; retired=4; state=HALT; instr=0 at pc=16; fault=0.
- Jump at pc=8 with instr_index=26'h000010 -> next pc=32'h40; retired increments once. With FETCH_DELAY_SLOT_EN: pc sequence 12 then 32'h40.
- Branch at pc=20, zero=1, imm16=16'hFFFB -> next pc=4. Same with zero=0 -> next pc=24.
- run=0; pulse step three times, holding step high two cycles each -> exactly 3 instructions; pc 0->12; state returns to IDLE after each step.
- IMEM_DEPTH=4, straight-line code with no halt word -> after pc=12 executes, pc=16, state=HALT, fault=1, retired=4.
- RST_N=0 mid-RUN at pc=28 with retired=7 -> next cycle pc=RESET_PC, retired=0, state=IDLE, instr=0.
